program_sequencer: RTL and testbench



---
 rtl/proc_pkg.sv | 33 +++
 rtl/program_sequencer_if.sv | 33 +++
 rtl/program_sequencer_pc_reg.sv | 28 ++
 rtl/program_sequencer.sv | 125 ++++++++++++
 tb/tb_program_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// proc_pkg - opcodes, sequencer state encoding, width defaults; rev 1.0
//------------------------------------------------------------------
package proc_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 10;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SHL   = 4'b0101;
    localparam logic [3:0] OP_LDI   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1001;
    localparam logic [3:0] OP_OUT   = 4'b1010;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LATCH    = 3'd2,
        EXEC     = 3'd3,
        OUT_WAIT = 3'd4,
        HALT     = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/program_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------
// program_sequencer_if - instruction ROM port and LCD handshake; rev 1.0
//------------------------------------------------------------------
interface program_sequencer_if
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_rdata;
    logic               lcd_valid;
    logic [7:0]         lcd_data;
    logic               lcd_ready;

    modport master (
        output instr_addr,
        input  instr_rdata,
        output lcd_valid,
        output lcd_data,
        input  lcd_ready
    );

    modport slave (
        input  instr_addr,
        output instr_rdata,
        input  lcd_valid,
        input  lcd_data,
        output lcd_ready
    );
endinterface
`default_nettype wire

// File: rtl/program_sequencer_pc_reg.sv
`default_nettype none
//------------------------------------------------------------------
// pc_reg - program counter with clear > load > increment priority; rev 1.0
//------------------------------------------------------------------
module pc_reg #(
    parameter int PC_W = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            clr,
    input  wire logic            load,
    input  wire logic            inc,
    input  wire logic [PC_W-1:0] load_val,
    output logic      [PC_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
//------------------------------------------------------------------
// program_sequencer - fetch/latch/execute sequencer with OUT stall; rev 1.0
//------------------------------------------------------------------
module program_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int PROG_LAST = 63
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    program_sequencer_if.master     bus,
    output logic      [INSTR_W-1:0] ir,
    output logic                    exec_en,
    input  wire logic [7:0]         out_data,
    output logic                    halted,
    output logic      [PC_W-1:0]    pc
);
    localparam logic [PC_W-1:0] c_last_addr = PC_W'(PROG_LAST);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             w_pc_clr;
    logic             w_pc_load;
    logic             w_pc_inc;
    logic [7:0]       r_lcd_data;
    logic [3:0]       w_opcode;
    logic             w_at_last;
    logic [PC_W-1:0]  w_jmp_target;

    assign w_opcode     = ir[INSTR_W-1 -: 4];
    assign w_at_last    = (pc == c_last_addr);
    assign w_jmp_target = PC_W'(ir[5:0]);

    pc_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_pc_clr),
        .load     (w_pc_load),
        .inc      (w_pc_inc),
        .load_val (w_jmp_target),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= '0;
            r_lcd_data <= '0;
        end else begin
            if (r_state == LATCH) begin
                ir <= bus.instr_rdata;
            end
            if (r_state == EXEC && w_opcode == OP_OUT) begin
                r_lcd_data <= out_data;
            end
        end
    end

    // The halt check at PROG_LAST precedes the increment, so pc never wraps.
    always_comb begin
        w_state_next = r_state;
        w_pc_clr     = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_pc_clr     = 1'b1;
                    w_state_next = FETCH;
                end
            end
            FETCH: w_state_next = LATCH;
            LATCH: w_state_next = EXEC;
            EXEC: begin
                case (w_opcode)
                    OP_OUT: w_state_next = OUT_WAIT;
                    OP_HLT: w_state_next = HALT;
                    OP_JMP: begin
                        w_pc_load    = 1'b1;
                        w_state_next = FETCH;
                    end
                    default: begin
                        if (w_at_last) begin
                            w_state_next = HALT;
                        end else begin
                            w_pc_inc     = 1'b1;
                            w_state_next = FETCH;
                        end
                    end
                endcase
            end
            OUT_WAIT: begin
                if (bus.lcd_ready) begin
                    if (w_at_last) begin
                        w_state_next = HALT;
                    end else begin
                        w_pc_inc     = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears them at once.
    assign exec_en        = (r_state == EXEC);
    assign halted         = (r_state == HALT);
    assign bus.lcd_valid  = (r_state == OUT_WAIT);
    assign bus.lcd_data   = r_lcd_data;
    assign bus.instr_addr = pc;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
//------------------------------------------------------------------
// tb_program_sequencer - scoreboard bench for program_sequencer; rev 1.0
//------------------------------------------------------------------
module tb_program_sequencer;
    import proc_pkg::*;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 10;

    typedef struct {
        logic [7:0] pc;
        logic [9:0] ir;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;
    logic [7:0] out_data = 8'h00;
    logic [7:0] out_data_b = 8'h00;

    logic [INSTR_W-1:0] ir, ir_b;
    logic exec_en, exec_en_b, halted, halted_b;
    logic [PC_W-1:0] pc, pc_b;

    logic [INSTR_W-1:0] rom  [256];
    logic [INSTR_W-1:0] romb [256];

    ev_t        exp_q[$];
    logic [7:0] lcd_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exec_cnt = 0;
    int exec_cnt_b = 0;
    int last_exec_cyc = 0;
    int max_addr_b = 0;
    bit have_last = 0;
    bit spacing_en = 0;
    bit prev_exec = 0;

    program_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
    program_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_b ();

    program_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PROG_LAST(63)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .ir(ir),
        .exec_en(exec_en), .out_data(out_data), .halted(halted), .pc(pc)
    );

    program_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PROG_LAST(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b), .ir(ir_b),
        .exec_en(exec_en_b), .out_data(out_data_b), .halted(halted_b), .pc(pc_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.instr_rdata   <= rom[bus.instr_addr];
        bus_b.instr_rdata <= romb[bus_b.instr_addr];
    end

    assign bus_b.lcd_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int k = 0;
        while (!halted && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard: each exec strobe and each LCD handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exec_en) begin
                ev_t ev;
                chk("exec_back_to_back", 32'(prev_exec), 32'd0);
                if (spacing_en && have_last) chk("exec_spacing", 32'(cyc - last_exec_cyc), 32'd3);
                have_last = 1;
                last_exec_cyc = cyc;
                chk("exec_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    chk("exec_pc", 32'(pc), 32'(ev.pc));
                    chk("exec_ir", 32'(ir), 32'(ev.ir));
                end
                exec_cnt++;
            end
            if (bus.lcd_valid && bus.lcd_ready) begin
                chk("lcd_expected", 32'(lcd_q.size() != 0), 32'd1);
                if (lcd_q.size() != 0) chk("lcd_handshake_data", 32'(bus.lcd_data), 32'(lcd_q.pop_front()));
            end
            if (exec_en_b) exec_cnt_b++;
            if (int'(bus_b.instr_addr) > max_addr_b) max_addr_b = int'(bus_b.instr_addr);
            prev_exec = exec_en;
        end else begin
            prev_exec = 0;
        end
    end

    initial begin
        bus.lcd_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]  = {OP_ADD, 6'd0};
            romb[i] = {OP_ADD, 6'd0};
        end

        // Reset held with start high: every output stays at zero.
        for (int i = 0; i < 4; i++) rom[i] = {OP_ADD, 6'(i + 1)};
        rom[4] = {OP_HLT, 6'd0};
        start = 1'b1;
        #1 rst_n = 1'b0;
        tick(2);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_addr", 32'(bus.instr_addr), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_exec_en", 32'(exec_en), 32'd0);
        chk("rst_lcd_valid", 32'(bus.lcd_valid), 32'd0);
        chk("rst_lcd_data", 32'(bus.lcd_data), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_b_pc", 32'(pc_b), 32'd0);

        // Straight-line ADD program ending in HLT at address 4.
        for (int i = 0; i < 5; i++) exp_q.push_back('{pc: 8'(i), ir: rom[i]});
        exec_cnt = 0;
        spacing_en = 1;
        have_last = 0;
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_fetch_addr", 32'(bus.instr_addr), 32'd0);
        chk("c1_exec_en", 32'(exec_en), 32'd0);
        tick();
        chk("c2_exec_en", 32'(exec_en), 32'd0);
        tick();
        chk("c3_exec_en", 32'(exec_en), 32'd1);
        tick();
        chk("c4_pc", 32'(pc), 32'd1);
        wait_halt(30, "line_halt");
        chk("line_exec_count", 32'(exec_cnt), 32'd5);
        chk("line_halt_pc", 32'(pc), 32'd4);
        tick(10);
        chk("line_pc_frozen", 32'(pc), 32'd4);
        chk("line_still_halted", 32'(halted), 32'd1);
        chk("line_sb_drained", 32'(exp_q.size()), 32'd0);

        // JMP at address 2 back to 0, three loop iterations.
        rom[0] = {OP_ADD, 6'd7};
        rom[1] = {OP_SUB, 6'd9};
        rom[2] = {OP_JMP, 6'd0};
        for (int it = 0; it < 3; it++)
            for (int a = 0; a < 3; a++) exp_q.push_back('{pc: 8'(a), ir: rom[a]});
        have_last = 0;
        pulse_start();
        chk("jmp_restart_unhalted", 32'(halted), 32'd0);
        begin
            int k = 0;
            while (exp_q.size() != 0 && k < 40) begin
                tick();
                k++;
                chk("jmp_no_halt", 32'(halted), 32'd0);
            end
        end
        chk("jmp_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("jmp_pc_zero", 32'(pc), 32'd0);
        rst_n = 1'b0;
        spacing_en = 0;
        tick();

        // OUT stalls four cycles with lcd_ready low; data must not follow out_data.
        rom[0] = {OP_OUT, 6'd0};
        rom[1] = {OP_HLT, 6'd0};
        out_data = 8'hA5;
        exp_q.push_back('{pc: 8'd0, ir: rom[0]});
        exp_q.push_back('{pc: 8'd1, ir: rom[1]});
        lcd_q.push_back(8'hA5);
        rst_n = 1'b1;
        tick();
        pulse_start();
        tick(2);
        chk("out_exec_en", 32'(exec_en), 32'd1);
        chk("out_valid_not_yet", 32'(bus.lcd_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(bus.lcd_valid), 32'd1);
            chk("stall_data", 32'(bus.lcd_data), 32'hA5);
            chk("stall_exec_en", 32'(exec_en), 32'd0);
            chk("stall_pc", 32'(pc), 32'd0);
            if (i == 0) out_data = 8'h3C;
            tick();
        end
        bus.lcd_ready = 1'b1;
        chk("stall_valid_5th", 32'(bus.lcd_valid), 32'd1);
        chk("stall_data_5th", 32'(bus.lcd_data), 32'hA5);
        tick();
        bus.lcd_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.lcd_valid), 32'd0);
        chk("post_hs_pc", 32'(pc), 32'd1);
        wait_halt(20, "out_halt");
        chk("out_halt_pc", 32'(pc), 32'd1);
        chk("out_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("lcd_sb_drained", 32'(lcd_q.size()), 32'd0);

        // PROG_LAST=3 instance: ADD at 3 halts without fetching 4.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exec_cnt_b = 0;
        begin
            int k = 0;
            while (!halted_b && k < 30) begin
                tick();
                k++;
            end
        end
        chk("b_halted", 32'(halted_b), 32'd1);
        chk("b_halt_pc", 32'(pc_b), 32'd3);
        chk("b_exec_count", 32'(exec_cnt_b), 32'd4);
        chk("b_max_addr", 32'(max_addr_b), 32'd3);

        // JMP to itself at PROG_LAST keeps looping.
        romb[3] = {OP_JMP, 6'd3};
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        exec_cnt_b = 0;
        tick(30);
        chk("b_loop_no_halt", 32'(halted_b), 32'd0);
        chk("b_loop_pc", 32'(pc_b), 32'd3);
        chk("b_loop_execs", 32'(exec_cnt_b >= 9), 32'd1);
        chk("b_loop_max_addr", 32'(max_addr_b), 32'd3);

        // Asynchronous reset in the middle of OUT_WAIT.
        out_data = 8'h5A;
        exp_q.push_back('{pc: 8'd0, ir: rom[0]});
        pulse_start();
        tick(3);
        chk("mid_out_valid", 32'(bus.lcd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.lcd_valid), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_lcd_data", 32'(bus.lcd_data), 32'd0);
        chk("async_rst_ir", 32'(ir), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
        tick();
        rst_n = 1'b1;
        exec_cnt = 0;
        tick(6);
        chk("idle_no_exec", 32'(exec_cnt), 32'd0);
        chk("idle_valid", 32'(bus.lcd_valid), 32'd0);
        chk("idle_pc", 32'(pc), 32'd0);
        chk("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
